// File: rtl/timer_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_sched: one shared time base plus a sequential earliest-deadline scan
// feeding per-channel pending interrupts. Macro: TIMER_SCHED_PERIODIC_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module timer_sched #(
  parameter int NumCh      = 4,
  parameter int CntWidth   = 32,
  parameter int PrescWidth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [$clog2(NumCh)-1:0] wr_ch_i,
  input  logic                     wr_arm_i,
  input  logic [CntWidth-1:0]      wr_deadline_i,
  input  logic [CntWidth-1:0]      wr_period_i,
  input  logic [PrescWidth-1:0]    prescaler_i,
  input  logic                     irq_ack_i,
  output logic                     irq_valid_o,
  output logic [$clog2(NumCh)-1:0] irq_ch_o,
  output logic [CntWidth-1:0]      now_o,
  output logic                     next_valid_o,
  output logic [$clog2(NumCh)-1:0] next_ch_o,
  output logic [CntWidth-1:0]      next_deadline_o
);
  localparam int ChW = $clog2(NumCh);
  localparam int PcW = (1 << PrescWidth) - 1;

  typedef enum logic [0:0] {
    SCAN   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ChW-1:0]      idx_q, idx_d;
  logic [ChW-1:0]      best_ch_q, best_ch_d;
  logic [CntWidth-1:0] best_dl_q, best_dl_d;
  logic                best_vld_q, best_vld_d;

  logic [PcW-1:0]      presc_cnt_q, presc_top;
  logic [CntWidth-1:0] now_q;
  logic [NumCh-1:0]    armed_q, pending_q, pending_d;
  logic [CntWidth-1:0] deadline_q [NumCh];
  logic                next_valid_q;
  logic [ChW-1:0]      next_ch_q;
  logic [CntWidth-1:0] next_dl_q;

  logic                tick, expire, abort, cand_better;
  logic [CntWidth-1:0] due_diff, cand_diff, best_diff;

  assign presc_top = (PcW'(1) << prescaler_i) - PcW'(1);
  assign tick      = (presc_cnt_q == presc_top);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt_q <= '0;
      now_q       <= '0;
    end else if (tick) begin
      presc_cnt_q <= '0;
      now_q       <= now_q + CntWidth'(1);
    end else begin
      presc_cnt_q <= presc_cnt_q + PcW'(1);
    end
  end

  // All differences are taken modulo 2^CntWidth and read as signed values.
  assign due_diff    = next_dl_q - now_q;
  assign expire      = next_valid_q && (due_diff[CntWidth-1] || (due_diff == '0));
  assign abort       = wr_en_i || expire;
  assign cand_diff   = deadline_q[idx_q] - now_q;
  assign best_diff   = best_dl_q - now_q;
  assign cand_better = armed_q[idx_q] &&
                       (!best_vld_q || ($signed(cand_diff) < $signed(best_diff)));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_ch_d  = best_ch_q;
    best_dl_d  = best_dl_q;
    best_vld_d = best_vld_q;
    if (abort || (state_q == COMMIT)) begin
      state_d    = SCAN;
      idx_d      = '0;
      best_ch_d  = '0;
      best_dl_d  = '0;
      best_vld_d = 1'b0;
    end else begin
      if (cand_better) begin
        best_ch_d  = idx_q;
        best_dl_d  = deadline_q[idx_q];
        best_vld_d = 1'b1;
      end
      if (idx_q == ChW'(NumCh - 1)) begin
        state_d = COMMIT;
      end else begin
        idx_d = idx_q + ChW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SCAN;
      idx_q      <= '0;
      best_ch_q  <= '0;
      best_dl_q  <= '0;
      best_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_ch_q  <= best_ch_d;
      best_dl_q  <= best_dl_d;
      best_vld_q <= best_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_valid_q <= 1'b0;
      next_ch_q    <= '0;
      next_dl_q    <= '0;
    end else if (!abort && (state_q == COMMIT)) begin
      next_valid_q <= best_vld_q;
      next_ch_q    <= best_ch_q;
      next_dl_q    <= best_dl_q;
    end else if (expire || (wr_en_i && (wr_ch_i == next_ch_q))) begin
      next_valid_q <= 1'b0;
    end
  end

`ifdef TIMER_SCHED_PERIODIC_EN
  logic [CntWidth-1:0] period_q [NumCh];
`else
  logic unused_period;
  assign unused_period = ^wr_period_i;
`endif

  // A write in the same cycle as an expiry of that channel overrides it.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q <= '0;
      for (int i = 0; i < NumCh; i++) begin
        deadline_q[i] <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
        period_q[i]   <= '0;
`endif
      end
    end else begin
      if (expire) begin
`ifdef TIMER_SCHED_PERIODIC_EN
        if (period_q[next_ch_q] != '0) begin
          deadline_q[next_ch_q] <= deadline_q[next_ch_q] + period_q[next_ch_q];
        end else begin
          armed_q[next_ch_q] <= 1'b0;
        end
`else
        armed_q[next_ch_q] <= 1'b0;
`endif
      end
      if (wr_en_i) begin
        armed_q[wr_ch_i] <= wr_arm_i;
        if (wr_arm_i) begin
          deadline_q[wr_ch_i] <= wr_deadline_i;
`ifdef TIMER_SCHED_PERIODIC_EN
          period_q[wr_ch_i]   <= wr_period_i;
`endif
        end
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (irq_ack_i && irq_valid_o) begin
      pending_d[irq_ch_o] = 1'b0;
    end
    if (expire) begin
      pending_d[next_ch_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    irq_ch_o = '0;
    for (int i = NumCh - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        irq_ch_o = ChW'(i);
      end
    end
  end

  assign irq_valid_o     = |pending_q;
  assign now_o           = now_q;
  assign next_valid_o    = next_valid_q;
  assign next_ch_o       = next_ch_q;
  assign next_deadline_o = next_dl_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_sched.sv
`default_nettype none
// Bench for timer_sched: directed vector table, hand sequences (true wrap on
// an 8-bit instance, periodic reload) and a randomized run against a model.
module tb_timer_sched;
  localparam int NumCh = 4;
  localparam int ChW   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0, wr_arm = 1'b0, irq_ack = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [31:0] wr_dl = '0, wr_per = '0;
  logic [3:0]  presc = '0;
  logic        irq_valid, next_valid;
  logic [1:0]  irq_ch, next_ch;
  logic [31:0] now, next_dl;

  logic        w8_en = 1'b0;
  logic [1:0]  w8_ch = '0;
  logic [7:0]  w8_dl = '0;
  logic        irq8_v, nv8;
  logic [1:0]  irq8_ch, nch8;
  logic [7:0]  now8, ndl8;

  logic [69:0] obs;
  assign obs = {irq_valid, irq_ch, now, next_valid, next_ch, next_dl};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  timer_sched #(.NumCh(NumCh), .CntWidth(32), .PrescWidth(4)) u_dut (
    .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_ch_i(wr_ch), .wr_arm_i(wr_arm),
    .wr_deadline_i(wr_dl), .wr_period_i(wr_per), .prescaler_i(presc), .irq_ack_i(irq_ack),
    .irq_valid_o(irq_valid), .irq_ch_o(irq_ch), .now_o(now), .next_valid_o(next_valid),
    .next_ch_o(next_ch), .next_deadline_o(next_dl)
  );

  timer_sched #(.NumCh(NumCh), .CntWidth(8), .PrescWidth(4)) u_dut8 (
    .clk(clk), .reset(reset), .wr_en_i(w8_en), .wr_ch_i(w8_ch), .wr_arm_i(1'b1),
    .wr_deadline_i(w8_dl), .wr_period_i(8'd0), .prescaler_i(4'd0), .irq_ack_i(1'b0),
    .irq_valid_o(irq8_v), .irq_ch_o(irq8_ch), .now_o(now8), .next_valid_o(nv8),
    .next_ch_o(nch8), .next_deadline_o(ndl8)
  );

  typedef struct packed {
    logic        wr;
    logic [1:0]  ch;
    logic        arm;
    logic [31:0] dl;
    logic        ack;
    int          hold;
    logic        iv;
    logic [1:0]  ic;
    logic [31:0] nw;
    logic        nv;
    logic [1:0]  nc;
    logic [31:0] nd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic wr, logic [1:0] ch, logic arm, logic [31:0] dl, logic ack,
                              int hold, logic iv, logic [1:0] ic, logic [31:0] nw, logic nv,
                              logic [1:0] nc, logic [31:0] nd);
    vec_t v;
    v = '{wr, ch, arm, dl, ack, hold, iv, ic, nw, nv, nc, nd};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: channel tables, a schedule refreshed every NumCh+1 cycles
  // after the last write/expiry, and the earliest armed deadline picked by arithmetic.
  logic [31:0]      m_now, m_ndl;
  logic [31:0]      m_dl  [NumCh];
  logic [31:0]      m_per [NumCh];
  logic [NumCh-1:0] m_armed, m_pend;
  logic             m_nv;
  logic [1:0]       m_nch;
  int               m_cnt, m_phase;

  function automatic int sd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return $signed(d);
  endfunction

  task automatic model_step(input logic rst, input logic wr, input logic [1:0] ch,
                            input logic arm, input logic [31:0] dl, input logic [31:0] per,
                            input logic ack, input logic [3:0] p);
    logic       due, abort;
    logic [1:0] onc;
    int         best;
    if (rst) begin
      m_now = '0; m_ndl = '0; m_armed = '0; m_pend = '0; m_nv = 1'b0; m_nch = '0;
      m_cnt = 0; m_phase = 0;
      for (int i = 0; i < NumCh; i++) begin
        m_dl[i] = '0;
        m_per[i] = '0;
      end
      return;
    end
    due   = m_nv && (sd(m_ndl, m_now) <= 0);
    abort = wr || due;
    onc   = m_nch;
    if (!abort && (m_phase == NumCh)) begin
      best = -1;
      for (int i = 0; i < NumCh; i++) begin
        if (m_armed[i] && ((best < 0) || (sd(m_dl[i], m_now) < sd(m_dl[best], m_now)))) best = i;
      end
      m_nv  = (best >= 0);
      m_nch = (best >= 0) ? 2'(best) : 2'd0;
      m_ndl = (best >= 0) ? m_dl[best] : 32'd0;
    end else if (due || (wr && (ch == m_nch))) begin
      m_nv = 1'b0;
    end
    m_phase = (abort || (m_phase == NumCh)) ? 0 : m_phase + 1;
    if (ack && (m_pend != '0)) begin
      for (int i = 0; i < NumCh; i++) begin
        if (m_pend[i]) begin
          m_pend[i] = 1'b0;
          break;
        end
      end
    end
    if (due) begin
      m_pend[onc] = 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
      if (m_per[onc] != 0) m_dl[onc] = m_dl[onc] + m_per[onc];
      else m_armed[onc] = 1'b0;
`else
      m_armed[onc] = 1'b0;
`endif
    end
    if (wr) begin
      m_armed[ch] = arm;
      if (arm) begin
        m_dl[ch]  = dl;
        m_per[ch] = per;
      end
    end
    if (m_cnt == ((1 << p) - 1)) begin
      m_cnt = 0;
      m_now = m_now + 32'd1;
    end else begin
      m_cnt = (m_cnt + 1) & 32'h7FFF;
    end
  endtask

  function automatic logic [69:0] model_obs();
    logic [1:0] ic;
    ic = '0;
    for (int i = NumCh - 1; i >= 0; i--) if (m_pend[i]) ic = 2'(i);
    return {|m_pend, ic, m_now, m_nv, m_nch, m_ndl};
  endfunction

  initial begin
    int          q_now[$];
    int          exp_now[$];
    logic        prev, found;
    logic [7:0]  irq_at;

    repeat (3) tick();
    check("reset_state", obs, '0);
    reset = 1'b0;

    vt.push_back(mk(0, 0, 0, 0,            0,  9, 0, 0,  10, 0, 0, 0));
    vt.push_back(mk(1, 2, 1, 50,           0,  0, 0, 0,  11, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0,            0,  3, 0, 0,  15, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0,            0,  0, 0, 0,  16, 1, 2, 50));
    vt.push_back(mk(0, 0, 0, 0,            0, 33, 0, 0,  50, 1, 2, 50));
    vt.push_back(mk(0, 0, 0, 0,            0,  0, 1, 2,  51, 0, 2, 50));
    vt.push_back(mk(0, 0, 0, 0,            1,  0, 0, 0,  52, 0, 2, 50));
    vt.push_back(mk(0, 0, 0, 0,            0,  3, 0, 0,  56, 0, 0, 0));
    vt.push_back(mk(1, 1, 1, 100,          0,  0, 0, 0,  57, 0, 0, 0));
    vt.push_back(mk(1, 3, 1, 80,           0,  0, 0, 0,  58, 0, 0, 0));
    vt.push_back(mk(1, 0, 1, 80,           0,  0, 0, 0,  59, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0,            0,  3, 0, 0,  63, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0,            0,  0, 0, 0,  64, 1, 0, 80));
    vt.push_back(mk(0, 0, 0, 0,            0, 15, 0, 0,  80, 1, 0, 80));
    vt.push_back(mk(0, 0, 0, 0,            0,  0, 1, 0,  81, 0, 0, 80));
    vt.push_back(mk(0, 0, 0, 0,            0,  4, 1, 0,  86, 1, 3, 80));
    vt.push_back(mk(0, 0, 0, 0,            0,  0, 1, 0,  87, 0, 3, 80));
    vt.push_back(mk(0, 0, 0, 0,            1,  0, 1, 3,  88, 0, 3, 80));
    vt.push_back(mk(0, 0, 0, 0,            1,  0, 0, 0,  89, 0, 3, 80));
    vt.push_back(mk(0, 0, 0, 0,            0,  2, 0, 0,  92, 1, 1, 100));
    vt.push_back(mk(0, 0, 0, 0,            0,  5, 0, 0,  98, 1, 1, 100));
    vt.push_back(mk(1, 1, 0, 0,            0,  0, 0, 0,  99, 0, 1, 100));
    vt.push_back(mk(0, 0, 0, 0,            0, 10, 0, 0, 110, 0, 0, 0));
    vt.push_back(mk(1, 2, 1, 105,          0,  0, 0, 0, 111, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0,            0,  4, 0, 0, 116, 1, 2, 105));
    vt.push_back(mk(0, 0, 0, 0,            0,  0, 1, 2, 117, 0, 2, 105));
    vt.push_back(mk(0, 0, 0, 0,            1,  0, 0, 0, 118, 0, 2, 105));
    vt.push_back(mk(1, 0, 1, 32'hFFFF_FFF0, 0, 0, 0, 0, 119, 0, 2, 105));
    vt.push_back(mk(1, 1, 1, 32'h7FFF_FF00, 0, 0, 0, 0, 120, 0, 2, 105));
    vt.push_back(mk(0, 0, 0, 0,            0,  3, 0, 0, 124, 0, 2, 105));
    vt.push_back(mk(0, 0, 0, 0,            0,  0, 0, 0, 125, 1, 0, 32'hFFFF_FFF0));
    vt.push_back(mk(0, 0, 0, 0,            0,  0, 1, 0, 126, 0, 0, 32'hFFFF_FFF0));
    vt.push_back(mk(0, 0, 0, 0,            1,  0, 0, 0, 127, 0, 0, 32'hFFFF_FFF0));
    vt.push_back(mk(0, 0, 0, 0,            0,  3, 0, 0, 131, 1, 1, 32'h7FFF_FF00));
    vt.push_back(mk(0, 0, 0, 0,            0, 20, 0, 0, 152, 1, 1, 32'h7FFF_FF00));

    foreach (vt[i]) begin
      wr_en = vt[i].wr; wr_ch = vt[i].ch; wr_arm = vt[i].arm; wr_dl = vt[i].dl;
      irq_ack = vt[i].ack;
      tick();
      wr_en = 1'b0; irq_ack = 1'b0;
      repeat (vt[i].hold) tick();
      check($sformatf("vec%0d", i), obs,
            {vt[i].iv, vt[i].ic, vt[i].nw, vt[i].nv, vt[i].nc, vt[i].nd});
    end

    // True counter wrap on the 8-bit instance: arm 8 at now=0xF0.
    for (int c = 0; c < 300 && now8 != 8'hF0; c++) tick();
    check("wrap_reach_f0", {62'd0, now8}, {62'd0, 8'hF0});
    w8_en = 1'b1; w8_ch = 2'd1; w8_dl = 8'd8;
    tick();
    w8_en = 1'b0;
    found = 1'b0; irq_at = '0;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      if (irq8_v) begin
        found = 1'b1;
        irq_at = now8;
      end
    end
    check("wrap_irq_now", {61'd0, found, irq_at}, {61'd0, 1'b1, 8'd9});
    check("wrap_irq_ch", {68'd0, irq8_ch}, {68'd0, 2'd1});

    // Reset with channels armed must discard everything.
    reset = 1'b1;
    repeat (2) tick();
    check("reset_mid_run", obs, '0);
    reset = 1'b0;

    wr_en = 1'b1; wr_ch = 2'd0; wr_arm = 1'b1; wr_dl = 32'd20; wr_per = 32'd30;
    tick();
    wr_en = 1'b0; wr_per = 32'd0;
    prev = 1'b0;
    for (int c = 0; c < 150 && now < 100; c++) begin
      tick();
      if (irq_valid && !prev) q_now.push_back(int'(now));
      prev = irq_valid;
      irq_ack = irq_valid;
    end
    irq_ack = 1'b0;
`ifdef TIMER_SCHED_PERIODIC_EN
    exp_now = '{21, 51, 81};
`else
    exp_now = '{21};
`endif
    check("periodic_count", {38'd0, 32'(q_now.size())}, {38'd0, 32'(exp_now.size())});
    foreach (exp_now[i]) begin
      check($sformatf("periodic_hit%0d", i), {38'd0, (i < q_now.size()) ? q_now[i] : -1},
            {38'd0, exp_now[i]});
    end

    for (int c = 0; c < 3000; c++) begin
      reset = (c < 2) || ($urandom_range(0, 599) == 0);
      if ((m_cnt == 0) && ($urandom_range(0, 149) == 0)) presc = 4'($urandom_range(0, 2));
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_arm  = ($urandom_range(0, 4) != 0);
      wr_dl   = m_now + 32'($urandom_range(0, 48)) - 32'd8;
      wr_per  = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(5, 40));
      irq_ack = ($urandom_range(0, 3) == 0);
      model_step(reset, wr_en, wr_ch, wr_arm, wr_dl, wr_per, irq_ack, presc);
      tick();
      check("rand", obs, model_obs());
    end
    reset = 1'b0; wr_en = 1'b0; irq_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_sched.md
# timer_sched

Deadline scheduler that shares one free-running hardware time base between `NumCh` software timer channels. Software arms per-channel absolute deadlines. A sequential scan finds the earliest armed deadline, which is compared against the time base each cycle. On expiry the block raises a per-channel pending interrupt toward the interrupt controller. It sits beside the CSR timer peripheral and replaces per-channel counters with one shared counter plus a compare scheduler.

## Interface
- `NumCh`, 4, number of timer channels (2..16)
- `CntWidth`, 32, width of time base and deadlines
- `PrescWidth`, 4, width of prescaler shift field
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `wr_en`  in  1  channel write strobe, single cycle
- `wr_ch`  in  $clog2(NumCh)  channel written
- `wr_arm`  in  1  1 = arm with `wr_deadline`; 0 = disarm
- `wr_deadline`  in  CntWidth  absolute deadline in ticks
- `wr_period`  in  CntWidth  reload period; used only with `TIMER_SCHED_PERIODIC_EN`
- `prescaler`  in  PrescWidth  one tick every 2^`prescaler` clk cycles
- `irq_ack`  in  1  acknowledge of `irq_ch`
- `irq_valid`  out  1  at least one channel pending
- `irq_ch`  out  $clog2(NumCh)  lowest-index pending channel
- `now`  out  CntWidth  current time base
- `next_valid`  out  1  `next_ch`/`next_deadline` hold a scheduled deadline
- `next_ch`  out  $clog2(NumCh)  earliest armed channel
- `next_deadline`  out  CntWidth  its deadline

## Operation
- **Prescaler:** an internal counter counts 0..2^`prescaler`−1. When it reaches the top, it returns to 0 and `now` increments by 1, wrapping modulo 2^CntWidth. A change to `prescaler` takes effect at the next compare. If the counter is already above the new top, it counts up through its own wrap to 0.
- **Per-channel state:** `armed`, `deadline`, `pending` (and `period` when the macro is set).
- **Time comparison:** diff = signed(deadline − now), computed modulo 2^CntWidth. A deadline is *due* when diff ≤ 0. Ordering uses the smallest diff. This makes comparison wrap-safe when deadlines are within 2^(CntWidth−1) of `now`.
- **Scan FSM**, states SCAN and COMMIT:
  - SCAN visits channel `idx` = 0..NumCh−1, one per cycle. It keeps the best (smallest diff) armed channel. On ties, the lower index wins.
  - After idx = NumCh−1 it moves to COMMIT. COMMIT loads `next_*`, sets `next_valid` = any armed, and returns to SCAN with idx = 0.
  - Any `wr_en` or expiry aborts the current scan. The FSM restarts at SCAN idx = 0 on the next cycle, and COMMIT of the aborted scan is suppressed.
- **Expiry:**
  - When `next_valid` is set and `next_deadline` is due, the next edge sets `pending[next_ch]`, clears `armed[next_ch]` and clears `next_valid`.
  - Only one expiry occurs per cycle. Other due channels expire on later scans.
- **Writes:**
  - An arm write sets `armed` and loads `deadline`. A disarm write clears `armed`.
  - A write to `next_ch` clears `next_valid` on the next edge.
  - Writes never change `pending`.
  - A deadline already in the past expires after the first COMMIT.
- **Interrupt:**
  - `irq_valid` = OR of `pending`. `irq_ch` = priority encode of `pending`, lowest index first.
  - `irq_ack` while `irq_valid` is high clears `pending[irq_ch]`. `irq_ack` while `irq_valid` is low is ignored.
  - If an ack and an expiry hit the same channel in the same cycle, the set wins.

## Timing
- **Reset values:** `now` = 0, prescaler counter = 0, all `armed`/`pending`/`deadline`/`period` = 0, FSM = SCAN with idx = 0, `next_valid` = 0, `next_ch` = 0, `next_deadline` = 0, `irq_valid` = 0, `irq_ch` = 0.
- **Reset mid-scan:** discards the scan and all channel state.
- **Write to schedule:** write sampled at edge t; `next_*` valid after edge t+NumCh+1.
- **Expiry latency:** `now` reaches D at edge k with `next_deadline` = D. Pending is set at edge k+1, and `irq_valid` is high from k+1.
- **Ack:** pending clears at the edge sampling `irq_ack`, so `irq_valid`/`irq_ch` update the next cycle.
- **Outputs:** all registered except `irq_valid`/`irq_ch`, which are combinational from `pending` registers.

## Configuration
- **`TIMER_SCHED_PERIODIC_EN` defined:**
  - An arm write also stores `wr_period`.
  - On expiry with a nonzero period, `deadline` += period (modulo 2^CntWidth) and `armed` stays set. Pending is still set.
  - Period 0 behaves as one-shot.
- **Undefined:** all channels are one-shot, `wr_period` is ignored and no period storage is built.

## Test plan
- **Reset:** hold reset 3 cycles → all outputs 0; `now` increments 1 per cycle with `prescaler` = 0.
- **Single channel:** `prescaler` = 0; arm ch2 at 50 when `now` = 10 → `next_valid` with `next_ch` = 2 after NumCh+1 cycles; `irq_valid` with `irq_ch` = 2 one cycle after `now` = 50; `irq_ack` → `irq_valid` = 0 next cycle.
- **Ordering and tie:** arm ch1 = 100, ch3 = 80, ch0 = 80 → `next_ch` = 0 and `next_deadline` = 80; both ch0 and ch3 pending by `now` = 80+2·(NumCh+2); `irq_ch` = 0, then 3 after ack.
- **Wrap:** CntWidth = 32, `now` = 0xFFFF_FFF0, arm ch1 = 0x0000_0008 → expires when `now` = 8, not immediately.
- **Disarm and past deadline:** disarm the current `next_ch` 2 cycles before its deadline → no interrupt. Arm at `now` − 5 → pending within NumCh+3 cycles.
- **Periodic, with `TIMER_SCHED_PERIODIC_EN`:** arm ch0 with deadline 20, period 30 → pending at `now` = 21, 51, 81. Without the macro, only `now` = 21.
